// File: rtl/mgmt_irq_pkg.sv
// Shared constants and register decode for the management interrupt controller.
package mgmt_irq_pkg;

  localparam int unsigned IRQ_ID_W  = 6;
  localparam int unsigned IRQ_MAX_N = 32;
  localparam int unsigned IRQ_ADR_W = 5;
  localparam int unsigned IRQ_DAT_W = 32;

  localparam logic [IRQ_ADR_W-1:0] IRQ_REG_ENABLE   = 5'h00;
  localparam logic [IRQ_ADR_W-1:0] IRQ_REG_MODE     = 5'h04;
  localparam logic [IRQ_ADR_W-1:0] IRQ_REG_POLARITY = 5'h08;
  localparam logic [IRQ_ADR_W-1:0] IRQ_REG_PENDING  = 5'h0C;
  localparam logic [IRQ_ADR_W-1:0] IRQ_REG_ID       = 5'h10;

  typedef enum logic [2:0] {
    SEL_ENABLE,
    SEL_MODE,
    SEL_POLARITY,
    SEL_PENDING,
    SEL_ID,
    SEL_NONE
  } irq_reg_sel_e;

  // Word-aligned decode; byte-lane bits are don't-care.
  function automatic irq_reg_sel_e irq_decode(input logic [IRQ_ADR_W-1:0] adr);
    irq_reg_sel_e sel;
    case ({adr[IRQ_ADR_W-1:2], 2'b00})
      IRQ_REG_ENABLE:   sel = SEL_ENABLE;
      IRQ_REG_MODE:     sel = SEL_MODE;
      IRQ_REG_POLARITY: sel = SEL_POLARITY;
      IRQ_REG_PENDING:  sel = SEL_PENDING;
      IRQ_REG_ID:       sel = SEL_ID;
      default:          sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mgmt_irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous interrupt inputs.
module mgmt_irq_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mgmt_irq_ctrl.sv
// Interrupt aggregator: per-channel sync, edge/level pending, mask, priority ID, Wishbone regs.
module mgmt_irq_ctrl
  import mgmt_irq_pkg::*;
#(
  parameter int unsigned N_IRQ       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 core_clk,
  input  logic                 core_rstn,
  input  logic [N_IRQ-1:0]     irq_in,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [IRQ_ADR_W-1:0] wb_adr_i,
  input  logic [IRQ_DAT_W-1:0] wb_dat_i,
  output logic [IRQ_DAT_W-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 irq_out,
  output logic [IRQ_ID_W-1:0]  irq_id
);

  logic [N_IRQ-1:0] irq_sync;
  logic [N_IRQ-1:0] s_cur, s_prev;
  logic [N_IRQ-1:0] enable_q, mode_q, pol_q, pending_q;
  logic [N_IRQ-1:0] pending_d, clr, rise, active, wr_data;
  logic [IRQ_ID_W-1:0]  id_d;
  logic [IRQ_DAT_W-1:0] rd_d;
  logic                 access, wr;
  irq_reg_sel_e         sel;
  logic                 unused_bits;

  mgmt_irq_sync #(
    .WIDTH  (N_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (core_clk),
    .rst_n (core_rstn),
    .d     (irq_in),
    .q     (irq_sync)
  );

  // A strobe still high during the ack cycle is not a new access.
  assign access  = wb_stb_i & ~wb_ack_o;
  assign wr      = access & wb_we_i;
  assign sel     = irq_decode(wb_adr_i);
  assign wr_data = wb_dat_i[N_IRQ-1:0];
  assign clr     = (wr && sel == SEL_PENDING) ? wr_data : '0;

  assign s_cur  = irq_sync ^ ~pol_q;
  assign rise   = s_cur & ~s_prev;
  // Edge channels: sticky, set beats clear. Level channels: follow the input.
  assign pending_d = (mode_q & ((pending_q & ~clr) | rise)) | (~mode_q & s_cur);
  assign active    = pending_q & enable_q;

  always_comb begin
    id_d = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) id_d = IRQ_ID_W'(i + 1);
    end
  end

  always_comb begin
    rd_d = '0;
    case (sel)
      SEL_ENABLE:   rd_d = IRQ_DAT_W'(enable_q);
      SEL_MODE:     rd_d = IRQ_DAT_W'(mode_q);
      SEL_POLARITY: rd_d = IRQ_DAT_W'(pol_q);
      SEL_PENDING:  rd_d = IRQ_DAT_W'(pending_q);
      SEL_ID:       rd_d = IRQ_DAT_W'(irq_id);
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      s_prev    <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
      pending_q <= '0;
      irq_out   <= 1'b0;
      irq_id    <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      s_prev    <= s_cur;
      pending_q <= pending_d;
      irq_out   <= |active;
      irq_id    <= id_d;
      wb_ack_o  <= access;
      wb_dat_o  <= access ? rd_d : '0;
      if (wr && sel == SEL_ENABLE)   enable_q <= wr_data;
      if (wr && sel == SEL_MODE)     mode_q   <= wr_data;
      if (wr && sel == SEL_POLARITY) pol_q    <= wr_data;
    end
  end

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

endmodule

// File: tb/tb_mgmt_irq_ctrl.sv
// Directed self-checking bench for mgmt_irq_ctrl (N_IRQ=6 main DUT, N_IRQ=32 for width checks).
module tb_mgmt_irq_ctrl;

  logic        core_clk;
  logic        core_rstn;
  logic [5:0]  irq_in;
  logic        wb_stb;
  logic        wb_we;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [31:0] dat_o6, dat_o32;
  logic        ack6, ack32;
  logic        irq_out6, irq_out32;
  logic [5:0]  id6, id32;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [4:0] A_EN  = 5'h00;
  localparam logic [4:0] A_MD  = 5'h04;
  localparam logic [4:0] A_POL = 5'h08;
  localparam logic [4:0] A_PND = 5'h0C;
  localparam logic [4:0] A_ID  = 5'h10;
  localparam logic [4:0] A_BAD = 5'h14;

  mgmt_irq_ctrl #(.N_IRQ(6), .SYNC_STAGES(2)) dut (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .irq_in   (irq_in),
    .wb_stb_i (wb_stb),
    .wb_we_i  (wb_we),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_dat_o (dat_o6),
    .wb_ack_o (ack6),
    .irq_out  (irq_out6),
    .irq_id   (id6)
  );

  mgmt_irq_ctrl #(.N_IRQ(32), .SYNC_STAGES(2)) dut32 (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .irq_in   ({26'h0, irq_in}),
    .wb_stb_i (wb_stb),
    .wb_we_i  (wb_we),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_dat_o (dat_o32),
    .wb_ack_o (ack32),
    .irq_out  (irq_out32),
    .irq_id   (id32)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic bus_write(input logic [4:0] adr, input logic [31:0] data);
    @(negedge core_clk);
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat = data;
    @(negedge core_clk);
    check("wr_ack", {31'h0, ack6}, 32'h1);
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] adr, output logic [31:0] d6, output logic [31:0] d32);
    @(negedge core_clk);
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
    @(negedge core_clk);
    check("rd_ack", {31'h0, ack6}, 32'h1);
    d6 = dat_o6; d32 = dat_o32;
    wb_stb = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] d6, d32;
    bus_read(adr, d6, d32);
    check(tag, d6, exp);
  endtask

  logic [31:0] r6, r32;

  initial begin
    core_rstn = 1'b0;
    irq_in = 6'h3F;
    wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0;

    // Reset
    wait_n(3);
    check("rst_irq_out", {31'h0, irq_out6}, 32'h0);
    check("rst_irq_id",  {26'h0, id6}, 32'h0);
    check("rst_ack",     {31'h0, ack6}, 32'h0);
    check("rst_dat",     dat_o6, 32'h0);
    core_rstn = 1'b1;
    wait_n(5);
    read_chk("rst_enable", A_EN,  32'h0);
    read_chk("rst_mode",   A_MD,  32'h0);
    read_chk("rst_pol",    A_POL, 32'h0);
    read_chk("rst_pend",   A_PND, 32'h0);
    read_chk("rst_id",     A_ID,  32'h0);

    // Edge channel 2, rising
    irq_in = 6'b111011;
    wait_n(5);
    bus_write(A_POL, 32'h04);
    bus_write(A_MD,  32'h04);
    bus_write(A_PND, 32'h04);
    bus_write(A_EN,  32'h04);
    wait_n(2);
    check("edge_idle", {31'h0, irq_out6}, 32'h0);
    @(negedge core_clk);
    irq_in = 6'b111111;
    wait_n(2);
    irq_in = 6'b111011;
    wait_n(1);
    check("edge_early", {31'h0, irq_out6}, 32'h0);
    wait_n(1);
    check("edge_irq_out", {31'h0, irq_out6}, 32'h1);
    check("edge_irq_id",  {26'h0, id6}, 32'h3);
    read_chk("edge_pend", A_PND, 32'h04);
    bus_write(A_PND, 32'h04);
    check("clr_hold", {31'h0, irq_out6}, 32'h1);
    wait_n(1);
    check("clr_drop", {31'h0, irq_out6}, 32'h0);

    // Level active-low channel 0
    bus_write(A_MD,  32'h00);
    bus_write(A_POL, 32'h00);
    bus_write(A_EN,  32'h01);
    irq_in = 6'b111010;
    wait_n(5);
    check("lvl_irq_out", {31'h0, irq_out6}, 32'h1);
    check("lvl_irq_id",  {26'h0, id6}, 32'h1);
    bus_write(A_PND, 32'h01);
    read_chk("lvl_noclr", A_PND, 32'h05);
    irq_in = 6'b111011;
    wait_n(3);
    check("lvl_hold", {31'h0, irq_out6}, 32'h1);
    wait_n(1);
    check("lvl_drop", {31'h0, irq_out6}, 32'h0);
    irq_in = 6'b111111;

    // Priority: edge channels 1 and 4
    irq_in = 6'b101101;
    wait_n(5);
    bus_write(A_POL, 32'h12);
    bus_write(A_MD,  32'h12);
    bus_write(A_PND, 32'h12);
    bus_write(A_EN,  32'h12);
    @(negedge core_clk);
    irq_in = 6'b111111;
    wait_n(6);
    check("prio_irq_out", {31'h0, irq_out6}, 32'h1);
    check("prio_id_1",    {26'h0, id6}, 32'h2);
    read_chk("prio_id_reg", A_ID, 32'h2);
    read_chk("prio_mode",   A_MD, 32'h12);
    bus_write(A_PND, 32'h02);
    wait_n(1);
    check("prio_id_4", {26'h0, id6}, 32'h5);
    bus_write(A_PND, 32'h10);
    wait_n(1);
    check("prio_none_out", {31'h0, irq_out6}, 32'h0);
    check("prio_none_id",  {26'h0, id6}, 32'h0);

    // Edge on channel 3 lands on the same clock as its clear
    irq_in = 6'b110111;
    wait_n(5);
    bus_write(A_POL, 32'h1A);
    bus_write(A_MD,  32'h1A);
    wait_n(2);
    irq_in = 6'b111111;
    @(negedge core_clk);
    bus_write(A_PND, 32'h08);
    read_chk("setclr_pend", A_PND, 32'h08);
    bus_write(A_PND, 32'h08);
    read_chk("setclr_clr",  A_PND, 32'h00);

    // Mask: channel 5 pending while disabled
    bus_write(A_EN, 32'h00);
    irq_in = 6'b011111;
    wait_n(5);
    check("mask_off", {31'h0, irq_out6}, 32'h0);
    read_chk("mask_pend", A_PND, 32'h20);
    bus_write(A_EN, 32'h20);
    check("mask_pre", {31'h0, irq_out6}, 32'h0);
    wait_n(1);
    check("mask_on_out", {31'h0, irq_out6}, 32'h1);
    check("mask_on_id",  {26'h0, id6}, 32'h6);

    // Unmapped address and width masking
    read_chk("bad_addr", A_BAD, 32'h0);
    bus_write(A_EN, 32'hFFFF_FFFF);
    bus_read(A_EN, r6, r32);
    check("en_w6",  r6,  32'h0000_003F);
    check("en_w32", r32, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
